data_mem_subsystem: RTL and testbench
=====================================

# data_mem_subsystem

Byte-addressable RISC-V data memory with its store and load datapaths. It sits in the MEM stage between the ALU result and the register-file write-back. It performs SB/SH/SW stores through byte enables, and LB/LH/LW/LBU/LHU loads with sign or zero extension. It is built from three submodules: `store_datapath` (lane steering and byte enables), `data_memory` (word array plus registered read port) and `load_datapath` (lane select and extension).

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words (1 KiB); must be a power of two.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_read` input 1: load request; captures the read word on the next edge.
- `mem_write` input 1: store request; commits on the next edge.
- `load_type` input 3: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; 101–111 reserved.
- `store_type` input 2: 00 SB, 01 SH, 10 SW; 11 reserved.
- `addr` input 32: byte address (ALU result).
- `rs2_data` input 32: store data.
- `read_data` output 32: extended load result.
- `misaligned` output 1: present only with `DMEM_MISALIGN_CHK_EN`.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo the memory size. The byte offset is `addr[1:0]`.
- Store steering is combinational.
  - SB: byte `rs2_data[7:0]` is replicated to all four lanes; byte_enable = `4'b0001 << addr[1:0]`.
  - SH: halfword `rs2_data[15:0]` is replicated to both halves; byte_enable = `4'b1100` if `addr[1]`, else `4'b0011`; `addr[0]` is ignored.
  - SW: `rs2_data` as is; byte_enable = `4'b1111`; `addr[1:0]` is ignored.
  - `store_type` 11: byte_enable = 0, so no write occurs.
- Write: on the rising edge with `mem_write=1`, each enabled lane of the addressed word is updated. Disabled lanes keep their contents. Little-endian: lane 0 is bits [7:0], at byte offset 0.
- Read: on the rising edge with `mem_read=1`, the addressed word, `addr[1:0]` and `load_type` are captured into registers. With `mem_read=0` these registers hold, so `read_data` is stable.
- Load datapath is combinational from the captured values.
  - Byte select uses offset[1:0]; halfword select uses offset[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the full word.
  - Reserved `load_type` values give `read_data = 0`.
- Simultaneous read and write to the same word in one cycle: the read captures the old contents (read-before-write), and the write still commits.
- Memory array contents are not reset; they are undefined until written.

## Timing
- Store: one cycle. Data is visible to a read issued on the following edge.
- Load: one-cycle latency. `read_data` is valid after the edge on which `mem_read=1` was sampled, and holds until the next captured read.
- Reset: `read_data` = 0 immediately on `rst` assertion, regardless of `clk`. The captured offset and `load_type` registers are also cleared, to 0 and LB respectively.
- `rst` asserted during a write: the write edge is suppressed while `rst=1`.
- All three output-related registers are updated only on edges where `rst=0`.

## Configuration
- `DMEM_MISALIGN_CHK_EN` defined:
  - Adds the `misaligned` output, combinational from the current `addr`, type and request inputs.
  - It is 1 when SH/LH/LHU has `addr[0]=1`, or SW/LW has `addr[1:0]≠0`, during `mem_read` or `mem_write`.
  - A misaligned store forces byte_enable to 0, so no write occurs.
  - A misaligned load still captures the word, but `read_data` is forced to 0.
- `DMEM_MISALIGN_CHK_EN` undefined: the port is absent, and low address bits are silently ignored as described in Operation.

## Test plan
- SW 0xAABBCCDD @0x10, then LW @0x10 -> `read_data` = 0xAABBCCDD one cycle after the read.
- SB 0x0000007F @0x14, then LB @0x14 -> 0x0000007F. Word 0x14 lanes 1–3 are unchanged.
- SB 0x00000080 @0x15, then LBU @0x15 -> 0x00000080; LB @0x15 -> 0xFFFFFF80.
- SH 0x00008001 @0x20, then LH @0x20 -> 0xFFFF8001; LHU @0x20 -> 0x00008001.
- SW 0x11223344 @0x30, SH 0xBEEF @0x32, then LW @0x30 -> 0xBEEF3344. Assert `rst` afterwards -> `read_data` = 0 asynchronously.
- With `DMEM_MISALIGN_CHK_EN`: SW 0xFFFFFFFF @0x41 -> `misaligned` = 1, and a subsequent aligned LW @0x40 returns the prior contents. Same-cycle read/write of 0x10 returns the old word.

Source files
------------

// File: rtl/data_mem_subsystem_if.sv
// ---------------------------------------------------------------------------
// data_mem_subsystem_if
// Groups the MEM-stage request and response signals of the data memory.
//   master : drives mem_read, mem_write, load_type, store_type, addr, rs2_data;
//            receives read_data (and misaligned when enabled)
//   slave  : the data memory side
// Optional feature macro: DMEM_MISALIGN_CHK_EN adds the misaligned signal.
// ---------------------------------------------------------------------------
interface data_mem_subsystem_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  load_type;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] rs2_data;
  logic [31:0] read_data;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        misaligned;
`endif

`ifdef DMEM_MISALIGN_CHK_EN
  modport master (
    output mem_read, mem_write, load_type, store_type, addr, rs2_data,
    input  read_data, misaligned
  );
  modport slave (
    input  mem_read, mem_write, load_type, store_type, addr, rs2_data,
    output read_data, misaligned
  );
`else
  modport master (
    output mem_read, mem_write, load_type, store_type, addr, rs2_data,
    input  read_data
  );
  modport slave (
    input  mem_read, mem_write, load_type, store_type, addr, rs2_data,
    output read_data
  );
`endif
endinterface

// File: rtl/data_mem_subsystem.sv
// ---------------------------------------------------------------------------
// data_mem_subsystem
// Byte-addressable RISC-V data memory for the MEM stage: SB/SH/SW stores via
// byte enables, LB/LH/LW/LBU/LHU loads with sign/zero extension.
//
// Submodules (all in this file):
//   store_datapath : lane replication and byte enables (combinational)
//   data_memory    : word array, byte-enabled write, registered read word
//   load_datapath  : lane select and extension (combinational)
//
// Ports of data_mem_subsystem:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   dmem_if  : data_mem_subsystem_if.slave (requests, addr, store data,
//              read_data, and misaligned when enabled)
// Parameter DEPTH_WORDS (power of two) sets the number of 32-bit words;
// upper address bits are ignored, so accesses wrap modulo the memory size.
//
// Optional feature macro: DMEM_MISALIGN_CHK_EN
//   defined   : misaligned output; misaligned stores are dropped and
//               misaligned loads return 0
//   undefined : low address bits are ignored silently for SH/SW/LH/LW
// ---------------------------------------------------------------------------

module store_datapath (
  input  logic [1:0]  store_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rs2_data_i,
  input  logic        block_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o
);
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  always_comb begin
    wdata_o = '0;
    be_o    = '0;
    case (store_type_i)
      ST_SB: begin
        wdata_o = {4{rs2_data_i[7:0]}};
        be_o    = 4'b0001 << offset_i;
      end
      ST_SH: begin
        wdata_o = {2{rs2_data_i[15:0]}};
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
      end
      ST_SW: begin
        wdata_o = rs2_data_i;
        be_o    = 4'b1111;
      end
      default: ;
    endcase
    if (block_i) be_o = '0;
  end
endmodule

module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Array is never reset; rst only blocks the write on the edge it covers.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (be_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  // Non-blocking read of the same entry gives read-before-write on a collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

module load_datapath (
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  input  logic        zero_i,
  output logic [31:0] data_o
);
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (load_type_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LW:   data_o = word_i;
      LD_LBU:  data_o = {24'd0, byte_sel};
      LD_LHU:  data_o = {16'd0, half_sel};
      default: data_o = '0;
    endcase
    if (zero_i) data_o = '0;
  end
endmodule

module data_mem_subsystem #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_subsystem_if.slave dmem_if
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [IDX_W-1:0] idx;
  logic [1:0]       offset;
  logic             unused_addr_hi;

  assign idx            = dmem_if.addr[IDX_W+1:2];
  assign offset         = dmem_if.addr[1:0];
  assign unused_addr_hi = ^dmem_if.addr[31:IDX_W+2];

  logic st_block;
  logic ld_zero;

  logic [1:0] offset_q, offset_d;
  logic [2:0] ltype_q, ltype_d;

`ifdef DMEM_MISALIGN_CHK_EN
  logic st_mis, ld_mis;
  logic lmis_q, lmis_d;

  always_comb begin
    st_mis = dmem_if.mem_write &&
             (((dmem_if.store_type == ST_SH) && offset[0]) ||
              ((dmem_if.store_type == ST_SW) && (offset != 2'b00)));
    ld_mis = dmem_if.mem_read &&
             ((((dmem_if.load_type == LD_LH) || (dmem_if.load_type == LD_LHU)) && offset[0]) ||
              ((dmem_if.load_type == LD_LW) && (offset != 2'b00)));
  end

  assign dmem_if.misaligned = st_mis | ld_mis;
  assign st_block           = st_mis;
  assign ld_zero            = lmis_q;

  // The misaligned-load flag travels with the captured word so read_data
  // stays 0 until the next captured read.
  always_comb lmis_d = dmem_if.mem_read ? ld_mis : lmis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lmis_q <= 1'b0;
    else     lmis_q <= lmis_d;
  end
`else
  assign st_block = 1'b0;
  assign ld_zero  = 1'b0;
`endif

  always_comb begin
    offset_d = offset_q;
    ltype_d  = ltype_q;
    if (dmem_if.mem_read) begin
      offset_d = offset;
      ltype_d  = dmem_if.load_type;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= 2'b00;
      ltype_q  <= LD_LB;
    end else begin
      offset_q <= offset_d;
      ltype_q  <= ltype_d;
    end
  end

  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rword;

  store_datapath u_store (
    .store_type_i (dmem_if.store_type),
    .offset_i     (offset),
    .rs2_data_i   (dmem_if.rs2_data),
    .block_i      (st_block),
    .wdata_o      (wdata),
    .be_o         (be)
  );

  data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .idx_i   (idx),
    .we_i    (dmem_if.mem_write),
    .be_i    (be),
    .wdata_i (wdata),
    .re_i    (dmem_if.mem_read),
    .rdata_o (rword)
  );

  load_datapath u_load (
    .word_i      (rword),
    .offset_i    (offset_q),
    .load_type_i (ltype_q),
    .zero_i      (ld_zero),
    .data_o      (dmem_if.read_data)
  );
endmodule

// File: tb/tb_data_mem_subsystem.sv
// ---------------------------------------------------------------------------
// tb_data_mem_subsystem
// Directed stores/loads against data_mem_subsystem with hand-computed
// expected values. Build with DMEM_MISALIGN_CHK_EN defined to exercise the
// misaligned-access path; otherwise the low-bit-ignore behaviour is checked.
// ---------------------------------------------------------------------------
module tb_data_mem_subsystem;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, ST_RSV = 2'b11;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, LD_RSV = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_subsystem_if dmem_bus ();

  data_mem_subsystem #(.DEPTH_WORDS(256)) dut (
    .clk     (clk),
    .rst     (rst),
    .dmem_if (dmem_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_bus.mem_write  = 1'b1;
    dmem_bus.store_type = st;
    dmem_bus.addr       = a;
    dmem_bus.rs2_data   = d;
    @(negedge clk);
    dmem_bus.mem_write  = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] lt, input logic [31:0] a);
    @(negedge clk);
    dmem_bus.mem_read  = 1'b1;
    dmem_bus.load_type = lt;
    dmem_bus.addr      = a;
    @(negedge clk);
    dmem_bus.mem_read  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmem_bus.mem_read   = 1'b0;
    dmem_bus.mem_write  = 1'b0;
    dmem_bus.load_type  = LB;
    dmem_bus.store_type = SB;
    dmem_bus.addr       = '0;
    dmem_bus.rs2_data   = '0;

    #1 rst = 1'b1;
    #1 check("reset_async", dmem_bus.read_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_hold", dmem_bus.read_data, 32'h0);

    do_store(SW, 32'h10, 32'hAABBCCDD);
    do_load(LW, 32'h10);
    check("sw_lw", dmem_bus.read_data, 32'hAABBCCDD);
    repeat (3) @(negedge clk);
    check("lw_hold", dmem_bus.read_data, 32'hAABBCCDD);

    // same-cycle read and write of word 0x10
    @(negedge clk);
    dmem_bus.mem_read   = 1'b1;
    dmem_bus.load_type  = LW;
    dmem_bus.mem_write  = 1'b1;
    dmem_bus.store_type = SW;
    dmem_bus.addr       = 32'h10;
    dmem_bus.rs2_data   = 32'h55667788;
    @(negedge clk);
    dmem_bus.mem_read  = 1'b0;
    dmem_bus.mem_write = 1'b0;
    check("rbw_old", dmem_bus.read_data, 32'hAABBCCDD);
    do_load(LW, 32'h10);
    check("rbw_new", dmem_bus.read_data, 32'h55667788);

    do_store(SW, 32'h14, 32'h12345678);
    do_store(SB, 32'h14, 32'h0000007F);
    do_load(LB, 32'h14);
    check("sb_lb_pos", dmem_bus.read_data, 32'h0000007F);
    do_load(LW, 32'h14);
    check("sb_lanes_kept", dmem_bus.read_data, 32'h1234567F);

    do_store(SB, 32'h15, 32'h00000080);
    do_load(LBU, 32'h15);
    check("sb_lbu", dmem_bus.read_data, 32'h00000080);
    do_load(LB, 32'h15);
    check("sb_lb_neg", dmem_bus.read_data, 32'hFFFFFF80);
    do_load(LW, 32'h14);
    check("sb_lane1", dmem_bus.read_data, 32'h1234807F);

    do_store(SH, 32'h20, 32'h00008001);
    do_load(LH, 32'h20);
    check("sh_lh", dmem_bus.read_data, 32'hFFFF8001);
    do_load(LHU, 32'h20);
    check("sh_lhu", dmem_bus.read_data, 32'h00008001);

    do_store(SW, 32'h30, 32'h11223344);
    do_store(SH, 32'h32, 32'h0000BEEF);
    do_load(LW, 32'h30);
    check("sh_upper_lw", dmem_bus.read_data, 32'hBEEF3344);
    do_load(LH, 32'h32);
    check("lh_upper", dmem_bus.read_data, 32'hFFFFBEEF);
    do_load(LBU, 32'h33);
    check("lbu_lane3", dmem_bus.read_data, 32'h000000BE);
    do_load(LB, 32'h31);
    check("lb_lane1", dmem_bus.read_data, 32'h00000033);

    // async reset mid-cycle, with a write pending across the reset edge
    do_load(LW, 32'h30);
    #2 rst = 1'b1;
    #1 check("rst_async_mid", dmem_bus.read_data, 32'h0);
    dmem_bus.mem_write  = 1'b1;
    dmem_bus.store_type = SW;
    dmem_bus.addr       = 32'h30;
    dmem_bus.rs2_data   = 32'hDEADBEEF;
    @(negedge clk);
    dmem_bus.mem_write = 1'b0;
    rst = 1'b0;
    check("rst_released", dmem_bus.read_data, 32'h0);
    do_load(LW, 32'h30);
    check("rst_write_blocked", dmem_bus.read_data, 32'hBEEF3344);

    // wrap: 0x450 aliases 0x050 in a 1 KiB memory
    do_store(SW, 32'h450, 32'hCAFEF00D);
    do_load(LW, 32'h50);
    check("addr_wrap", dmem_bus.read_data, 32'hCAFEF00D);
    do_store(ST_RSV, 32'h50, 32'h00000000);
    do_load(LW, 32'h50);
    check("st_reserved", dmem_bus.read_data, 32'hCAFEF00D);
    do_load(LD_RSV, 32'h50);
    check("ld_reserved", dmem_bus.read_data, 32'h0);

`ifdef DMEM_MISALIGN_CHK_EN
    do_store(SW, 32'h40, 32'h0BADF00D);
    @(negedge clk);
    dmem_bus.mem_write  = 1'b1;
    dmem_bus.store_type = SW;
    dmem_bus.addr       = 32'h41;
    dmem_bus.rs2_data   = 32'hFFFFFFFF;
    #1 check("mis_sw_flag", {31'd0, dmem_bus.misaligned}, 32'h1);
    @(negedge clk);
    dmem_bus.mem_write = 1'b0;
    #1 check("mis_idle_flag", {31'd0, dmem_bus.misaligned}, 32'h0);
    do_load(LW, 32'h40);
    check("mis_sw_dropped", dmem_bus.read_data, 32'h0BADF00D);

    do_store(SH, 32'h43, 32'h00001234);
    do_load(LW, 32'h40);
    check("mis_sh_dropped", dmem_bus.read_data, 32'h0BADF00D);

    @(negedge clk);
    dmem_bus.mem_read  = 1'b1;
    dmem_bus.load_type = LH;
    dmem_bus.addr      = 32'h42;
    #1 check("aligned_lh_flag", {31'd0, dmem_bus.misaligned}, 32'h0);
    @(negedge clk);
    dmem_bus.mem_read = 1'b0;
    check("aligned_lh", dmem_bus.read_data, 32'h00000BAD);

    @(negedge clk);
    dmem_bus.mem_read  = 1'b1;
    dmem_bus.load_type = LHU;
    dmem_bus.addr      = 32'h41;
    #1 check("mis_lhu_flag", {31'd0, dmem_bus.misaligned}, 32'h1);
    @(negedge clk);
    dmem_bus.mem_read = 1'b0;
    check("mis_lhu_zero", dmem_bus.read_data, 32'h0);
`else
    do_store(SW, 32'h63, 32'h01020304);
    do_load(LW, 32'h60);
    check("sw_low_ignored", dmem_bus.read_data, 32'h01020304);
    do_store(SH, 32'h61, 32'h0000A5A5);
    do_load(LW, 32'h60);
    check("sh_a0_ignored", dmem_bus.read_data, 32'h0102A5A5);
    do_load(LH, 32'h63);
    check("lh_a0_ignored", dmem_bus.read_data, 32'h00000102);
    do_load(LW, 32'h62);
    check("lw_low_ignored", dmem_bus.read_data, 32'h0102A5A5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
